// File: rtl/color_sensor_pkg.sv
// Shared definitions for the color sensor front end: FSM state encoding,
// TCS3200 filter-select codes and measurement channel indices.
// Optional feature macro: COLOR_SENSOR_CLEAR_CHANNEL_EN adds a fourth (clear)
// channel after blue.
package color_sensor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        GATE,
        STORE,
        PUBLISH
    } state_t;

    // Filter select codes, presented as {s2, s3}
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_CLEAR = 2'b10;
    localparam logic [1:0] FILT_GREEN = 2'b11;

    // Channel indices in measurement order
    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;
    localparam logic [1:0] CH_C = 2'd3;

`ifdef COLOR_SENSOR_CLEAR_CHANNEL_EN
    localparam logic [1:0] CH_LAST = CH_C;
`else
    localparam logic [1:0] CH_LAST = CH_B;
`endif

    localparam int NUM_CH = int'(CH_LAST) + 1;

    // Filter code that selects the photodiode group for a given channel
    function automatic logic [1:0] filt_for_ch(input logic [1:0] ch);
        logic [1:0] code;
        case (ch)
            CH_R:    code = FILT_RED;
            CH_G:    code = FILT_GREEN;
            CH_B:    code = FILT_BLUE;
            CH_C:    code = FILT_CLEAR;
            default: code = FILT_RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/freq_edge_counter.sv
// Sensor input path: 2-flop synchronizer, registered rising-edge detector and
// a saturating edge counter with synchronous clear and count enable.
// A raw rising edge shows up as a one-cycle pulse three clocks later.
module freq_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sensor,
    input  logic             i_clear,
    input  logic             i_count_en,
    output logic [CNT_W-1:0] o_count
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             r_edge;
    logic [CNT_W-1:0] r_count;

    // Synchronize the asynchronous square wave and flag each rising edge
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= i_sensor;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_edge  <= r_sync2 & ~r_prev;
        end
    end

    // Count detected edges while enabled; stick at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && r_edge && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/color_sensor_reader.sv
// Color sensor reader: cycles the TCS3200 filter through red, green and blue,
// counts sensor pulses over a fixed gate per channel, and publishes all
// channel values together with a one-cycle valid strobe.
// Optional feature macro: COLOR_SENSOR_CLEAR_CHANNEL_EN adds a clear channel
// measured after blue and published on output C.
module color_sensor_reader
    import color_sensor_pkg::*;
#(
    parameter int GATE_CYCLES   = 50000,
    parameter int SETTLE_CYCLES = 100,
    parameter int CNT_W         = 16,
    parameter int SHIFT         = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       sensor_out,
    output logic       s2,
    output logic       s3,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       valid,
    output logic       busy
`ifdef COLOR_SENSOR_CLEAR_CHANNEL_EN
    ,
    output logic [7:0] C
`endif
);

    localparam int TMR_MAX  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    // The last channel's value goes straight to the output registers in the
    // STORE cycle, so only the earlier channels need holding.
    localparam int NUM_HELD = NUM_CH - 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_ch;
    logic [1:0]       w_ch_next;
    logic [1:0]       r_filt;
    logic [1:0]       w_filt_next;
    logic [TMR_W-1:0] r_timer;
    logic             w_timer_done;
    logic             w_publish;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_scaled;
    logic [7:0]       w_value;
    logic [7:0]       r_held [NUM_HELD];
    logic [7:0]       r_r;
    logic [7:0]       r_g;
    logic [7:0]       r_b;
    logic             r_valid;
`ifdef COLOR_SENSOR_CLEAR_CHANNEL_EN
    logic [7:0]       r_c;
`endif

    freq_edge_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst),
        .i_sensor   (sensor_out),
        .i_clear    (r_state != GATE),
        .i_count_en (r_state == GATE),
        .o_count    (w_count)
    );

    // Scale the raw count and clamp it into 8 bits
    assign w_scaled = w_count >> SHIFT;
    assign w_value  = (w_scaled > CNT_W'(255)) ? 8'hFF : w_scaled[7:0];

    // Next-state, channel and filter selection; enable low aborts the frame
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_ch_next    = r_ch;
        w_filt_next  = r_filt;
        w_publish    = 1'b0;
        w_timer_done = (r_state == SETTLE) ? (r_timer == SETTLE_LAST)
                                           : (r_timer == GATE_LAST);
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_next = SETTLE;
                    w_ch_next    = CH_R;
                    w_filt_next  = FILT_RED;
                end
            end
            SETTLE: begin
                if (!enable)          w_state_next = IDLE;
                else if (w_timer_done) w_state_next = GATE;
            end
            GATE: begin
                if (!enable)          w_state_next = IDLE;
                else if (w_timer_done) w_state_next = STORE;
            end
            STORE: begin
                if (!enable) begin
                    w_state_next = IDLE;
                end else if (r_ch == CH_LAST) begin
                    w_state_next = PUBLISH;
                    w_publish    = 1'b1;
                end else begin
                    w_state_next = SETTLE;
                    w_ch_next    = r_ch + 2'd1;
                    w_filt_next  = filt_for_ch(r_ch + 2'd1);
                end
            end
            PUBLISH: begin
                if (enable) begin
                    w_state_next = SETTLE;
                    w_ch_next    = CH_R;
                    w_filt_next  = FILT_RED;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, channel, filter select and phase timer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ch    <= CH_R;
            r_filt  <= FILT_RED;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_ch    <= w_ch_next;
            r_filt  <= w_filt_next;
            if ((w_state_next != r_state) || (r_state == IDLE)) r_timer <= '0;
            else                                                 r_timer <= r_timer + 1'b1;
        end
    end

    // Hold earlier channel values, then load all outputs together on publish
    // NOTE: the held-value array is small and must read as zero after reset,
    // so it is reset element by element like ordinary flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_HELD; i++) r_held[i] <= 8'd0;
            r_r     <= 8'd0;
            r_g     <= 8'd0;
            r_b     <= 8'd0;
            r_valid <= 1'b0;
`ifdef COLOR_SENSOR_CLEAR_CHANNEL_EN
            r_c     <= 8'd0;
`endif
        end else begin
            r_valid <= w_publish;
            if ((r_state == STORE) && enable) begin
                for (int i = 0; i < NUM_HELD; i++) begin
                    if (r_ch == 2'(i)) r_held[i] <= w_value;
                end
            end
            if (w_publish) begin
                r_r <= r_held[CH_R];
                r_g <= r_held[CH_G];
`ifdef COLOR_SENSOR_CLEAR_CHANNEL_EN
                r_b <= r_held[CH_B];
                r_c <= w_value;
`else
                r_b <= w_value;
`endif
            end
        end
    end

    assign s2    = r_filt[1];
    assign s3    = r_filt[0];
    assign R     = r_r;
    assign G     = r_g;
    assign B     = r_b;
    assign valid = r_valid;
    assign busy  = (r_state != IDLE);
`ifdef COLOR_SENSOR_CLEAR_CHANNEL_EN
    assign C     = r_c;
`endif

endmodule

// File: tb/tb_color_sensor_reader.sv
// Directed testbench for color_sensor_reader. Main instance: GATE=100,
// SETTLE=4, SHIFT=0. Two extra instances (GATE=1000, SHIFT=0 and SHIFT=2)
// are driven by a period-2 square wave to exercise 8-bit saturation.
module tb_color_sensor_reader;

    localparam int GATE   = 100;
    localparam int SETL   = 4;
`ifdef COLOR_SENSOR_CLEAR_CHANNEL_EN
    localparam int NCH    = 4;
`else
    localparam int NCH    = 3;
`endif
    localparam int FRAME     = NCH * (SETL + GATE + 1) + 1;
    localparam int SAT_GATE  = 1000;
    localparam int SAT_FRAME = NCH * (SETL + SAT_GATE + 1) + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       sensor_out;
    logic       s2, s3, valid, busy;
    logic [7:0] R, G, B;

    logic       en_sat;
    logic       sensor_fast;
    logic       sat_s2, sat_s3, sat_valid, sat_busy;
    logic [7:0] sat_R, sat_G, sat_B;
    logic       shr_s2, shr_s3, shr_valid, shr_busy;
    logic [7:0] shr_R, shr_G, shr_B;
`ifdef COLOR_SENSOR_CLEAR_CHANNEL_EN
    logic [7:0] C, sat_C, shr_C;
`endif

    int  n_cmp = 0;
    int  n_bad = 0;

    // Sensor stimulus controls
    bit  sensor_en = 1'b1;
    bit  fast_mode = 1'b0;
    bit  sat_sensor_en = 1'b1;
    int  ph = 0;

    color_sensor_reader #(
        .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETL), .CNT_W(16), .SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sensor_out(sensor_out),
        .s2(s2), .s3(s3), .R(R), .G(G), .B(B), .valid(valid), .busy(busy)
`ifdef COLOR_SENSOR_CLEAR_CHANNEL_EN
        , .C(C)
`endif
    );

    color_sensor_reader #(
        .GATE_CYCLES(SAT_GATE), .SETTLE_CYCLES(SETL), .CNT_W(16), .SHIFT(0)
    ) dut_sat (
        .clk(clk), .rst(rst), .enable(en_sat), .sensor_out(sensor_fast),
        .s2(sat_s2), .s3(sat_s3), .R(sat_R), .G(sat_G), .B(sat_B),
        .valid(sat_valid), .busy(sat_busy)
`ifdef COLOR_SENSOR_CLEAR_CHANNEL_EN
        , .C(sat_C)
`endif
    );

    color_sensor_reader #(
        .GATE_CYCLES(SAT_GATE), .SETTLE_CYCLES(SETL), .CNT_W(16), .SHIFT(2)
    ) dut_shr (
        .clk(clk), .rst(rst), .enable(en_sat), .sensor_out(sensor_fast),
        .s2(shr_s2), .s3(shr_s3), .R(shr_R), .G(shr_G), .B(shr_B),
        .valid(shr_valid), .busy(shr_busy)
`ifdef COLOR_SENSOR_CLEAR_CHANNEL_EN
        , .C(shr_C)
`endif
    );

    initial forever #5 clk = ~clk;

    // Sensor period in clk cycles for each filter code
    function automatic int period_for(input logic [1:0] f);
        case (f)
            2'b00:   return 4;
            2'b11:   return 10;
            2'b01:   return 20;
            default: return 8;
        endcase
    endfunction

    // Main sensor: square wave whose period follows the selected filter
    initial begin
        int per;
        sensor_out = 1'b0;
        forever begin
            @(negedge clk);
            per = fast_mode ? 2 : period_for({s2, s3});
            ph  = ph + 1;
            if (ph >= per) ph = 0;
            sensor_out = sensor_en && (ph < per / 2);
        end
    end

    // Saturation sensor: toggles every clock, period 2
    initial begin
        sensor_fast = 1'b0;
        forever begin
            @(negedge clk);
            sensor_fast = sat_sensor_en ? ~sensor_fast : 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input logic [31:0] obs,
                             input logic [31:0] lo, input logic [31:0] hi);
        n_cmp++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Wait for the main instance's valid strobe; cycles counts posedges
    task automatic wait_valid(input int budget, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                cycles = k;
                seen   = 1'b1;
                break;
            end
        end
    endtask

    logic [1:0] exp_seq [4] = '{2'b00, 2'b11, 2'b01, 2'b10};

    initial begin
        int         lat;
        bit         seen;
        int         bad;
        int         npulse;
        int         t_valid [3];
        logic [1:0] prev_f;
        logic [1:0] fseq [$];

        // Reset and idle
        rst = 1'b1; enable = 1'b0; en_sat = 1'b0;
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_R", R, 0);
        check("rst_G", G, 0);
        check("rst_B", B, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_s2s3", {s2, s3}, 2'b00);
        @(negedge clk) rst = 1'b1;
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (valid || busy || (R != 0) || (G != 0) || (B != 0)) bad++;
        end
        check("idle_quiet_cycles", bad, 0);

        // Nominal frame, enable dropped while PUBLISH is active
        @(negedge clk) enable = 1'b1;
        wait_valid(2 * FRAME, lat, seen);
        check("nom_valid_seen", seen, 1);
        check("nom_latency", lat, FRAME);
        check_rng("nom_R", R, 24, 26);
        check_rng("nom_G", G, 9, 11);
        check_rng("nom_B", B, 4, 6);
        enable = 1'b0;
        @(posedge clk); #1;
        check("nom_valid_width", valid, 0);
        check("nom_idle_after_publish", busy, 0);
        check_rng("nom_R_kept", R, 24, 26);

        // Mid-frame abort during green GATE with a much faster sensor
        fast_mode = 1'b1;
        @(negedge clk) enable = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(posedge clk); #1;
            if ({s2, s3} == 2'b11) begin seen = 1'b1; break; end
        end
        check("abort_reached_green", seen, 1);
        repeat (30) @(posedge clk);
        #1;
        check("abort_busy_in_gate", busy, 1);
        @(negedge clk) enable = 1'b0;
        @(posedge clk); #1;
        check("abort_idle_next_cycle", busy, 0);
        npulse = 0;
        repeat (2 * FRAME) begin
            @(posedge clk); #1;
            if (valid) npulse++;
        end
        check("abort_no_valid", npulse, 0);
        check("abort_filter_hold", {s2, s3}, 2'b11);
        check_rng("abort_R_kept", R, 24, 26);
        check_rng("abort_G_kept", G, 9, 11);
        check_rng("abort_B_kept", B, 4, 6);
        fast_mode = 1'b0;

        // Frame with no sensor edges publishes zeros
        sensor_en = 1'b0;
        @(negedge clk) enable = 1'b1;
        wait_valid(2 * FRAME, lat, seen);
        check("zero_valid_seen", seen, 1);
        check("zero_R", R, 0);
        check("zero_G", G, 0);
        check("zero_B", B, 0);
        enable = 1'b0;
        @(negedge clk) sensor_en = 1'b1;

        // Continuous run: three frames, spacing and filter sequence
        prev_f = {s2, s3};
        npulse = 0;
        @(negedge clk) enable = 1'b1;
        for (int k = 1; k <= 3 * FRAME + 50; k++) begin
            @(posedge clk); #1;
            if ({s2, s3} != prev_f) begin
                fseq.push_back({s2, s3});
                prev_f = {s2, s3};
            end
            if (valid) begin
                t_valid[npulse] = k;
                npulse++;
                if (npulse == 3) break;
            end
        end
        enable = 1'b0;
        check("cont_pulses", npulse, 3);
        check("cont_first_latency", t_valid[0], FRAME);
        check("cont_spacing_1_2", t_valid[1] - t_valid[0], FRAME);
        check("cont_spacing_2_3", t_valid[2] - t_valid[1], FRAME);
        check("cont_filter_changes", fseq.size(), 3 * NCH);
        bad = 0;
        foreach (fseq[i]) if (fseq[i] !== exp_seq[i % NCH]) bad++;
        check("cont_filter_seq_errs", bad, 0);
        check_rng("cont_R", R, 24, 26);
        check_rng("cont_G", G, 9, 11);
        check_rng("cont_B", B, 4, 6);

        // Asynchronous reset in the middle of the red GATE
        @(negedge clk) enable = 1'b1;
        repeat (60) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_R", R, 0);
        check("arst_G", G, 0);
        check("arst_B", B, 0);
        check("arst_valid", valid, 0);
        check("arst_busy", busy, 0);
        check("arst_s2s3", {s2, s3}, 2'b00);
        enable = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) enable = 1'b1;
        wait_valid(2 * FRAME, lat, seen);
        check("post_rst_latency", lat, FRAME);
        check_rng("post_rst_R", R, 24, 26);
        check_rng("post_rst_G", G, 9, 11);
        check_rng("post_rst_B", B, 4, 6);
        enable = 1'b0;

        // Saturation: 500 edges per gate clamp to 255, or 500>>2 = 125
        @(negedge clk) en_sat = 1'b1;
        lat = 0;
        for (int k = 1; k <= 2 * SAT_FRAME; k++) begin
            @(posedge clk); #1;
            if (sat_valid) begin lat = k; break; end
        end
        en_sat = 1'b0;
        check("sat_latency", lat, SAT_FRAME);
        check("sat_R", sat_R, 255);
        check("sat_G", sat_G, 255);
        check("sat_B", sat_B, 255);
        check("shr_valid_aligned", shr_valid, 1);
        check_rng("shr_R", shr_R, 124, 126);
        check_rng("shr_G", shr_G, 124, 126);
        check_rng("shr_B", shr_B, 124, 126);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit in case a wait above misbehaves
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "time limit");
    end

endmodule
